// File: rtl/img_proc_pkg.sv
// rtl/img_proc_pkg.sv - shared pixel/column types and FSM encoding for the image pipeline
// Purpose: common widths, pixel/column typedefs and the line-buffer FSM state enum.
// Ports: none (package).
package img_proc_pkg;

  localparam int PIX_W     = 8;
  localparam int WIN       = 5;
  localparam int NUM_LINES = WIN - 1;

  typedef logic [PIX_W-1:0]     pixel_t;
  typedef logic [WIN*PIX_W-1:0] column_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - single-port read-first line RAM with synchronous read
// Purpose: holds one image line of pixels; a read and an optional write to the same
//   address happen in one cycle, the read returning the old contents.
// Ports:
//   clk      in   clock
//   en       in   access enable (read, and write when we is also set)
//   we       in   write enable
//   addr     in   pixel column address
//   wr_data  in   pixel to store
//   rd_data  out  pixel read on the last enabled cycle (held otherwise)
module line_ram
  import img_proc_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wr_data,
  output pixel_t        rd_data
);

  pixel_t mem [DEPTH];
  pixel_t rd_data_q;
  pixel_t rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (en) begin
      rd_data_d = mem[addr];
    end
  end

  // Contents are never cleared; only freshly written lines are ever consumed.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (en && we) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_buffer_5row.sv
// rtl/line_buffer_5row.sv - 4-line buffer emitting 5-pixel vertical columns per raster pixel
// Purpose: stores the last four image lines and, for each accepted pixel, outputs the
//   column {current line, line-1, line-2, line-3, line-4} one cycle later.
// Configuration macro: BORDER_REPLICATE_EN - when defined, rows 0..3 also produce columns,
//   with lines above the image replaced by line 0.
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   pix_in      in   raster pixel
//   pix_valid   in   pixel valid (no backpressure)
//   sof         in   start of frame, qualified by pix_valid
//   col_out     out  column; [39:32] current line ... [7:0] oldest line
//   col_valid   out  col_out valid pulse
//   line_done   out  pulse with the column of the last pixel of a line
//   frame_done  out  pulse with the column of the last pixel of the frame
module line_buffer_5row
  import img_proc_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        sof,
  output logic [39:0] col_out,
  output logic        col_valid,
  output logic        line_done,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [2:0]    LS_FULL  = 3'(NUM_LINES);

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0]    ls_q, ls_d;
  logic [1:0]    wr_sel_q, wr_sel_d;
  pixel_t        pix_q, pix_d;
  logic [1:0]    sel_q, sel_d;
  logic          live_q, live_d;
  logic          col_valid_q, col_valid_d;
  logic          line_done_q, line_done_d;
  logic          frame_done_q, frame_done_d;
`ifdef BORDER_REPLICATE_EN
  logic [2:0]    out_ls_q, out_ls_d;
`endif

  logic          accept;
  logic          restart;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [2:0]    cur_ls;
  logic          last_col;
  logic          last_row;

  pixel_t  ram_rd [NUM_LINES];
  pixel_t  col_bytes [WIN];
  column_t col_asm;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pix_valid && sof) state_d = ACTIVE;
      ACTIVE:  state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
    if (accept && last_col && last_row) begin
      state_d = IDLE;
    end
  end

  // FSM: outputs. A sof pixel is accepted in either state and restarts the frame.
  always_comb begin
    restart = pix_valid && sof;
    accept  = pix_valid && (sof || (state_q == ACTIVE));
  end

  // Position of the pixel being accepted this cycle.
  always_comb begin
    cur_col  = restart ? '0 : col_q;
    cur_row  = restart ? '0 : row_q;
    cur_ls   = restart ? '0 : ls_q;
    last_col = (cur_col == COL_LAST);
    last_row = (cur_row == ROW_LAST);
  end

  // Counters, rotation and output pipeline next values.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    ls_d         = ls_q;
    wr_sel_d     = wr_sel_q;
    pix_d        = pix_q;
    sel_d        = sel_q;
    live_d       = live_q;
    col_valid_d  = 1'b0;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef BORDER_REPLICATE_EN
    out_ls_d     = out_ls_q;
`endif
    if (accept) begin
      pix_d  = pix_in;
      sel_d  = wr_sel_q;
      live_d = 1'b1;
`ifdef BORDER_REPLICATE_EN
      out_ls_d    = cur_ls;
      col_valid_d = 1'b1;
`else
      col_valid_d = (cur_ls == LS_FULL);
`endif
      row_d = cur_row;
      ls_d  = cur_ls;
      if (last_col) begin
        col_d        = '0;
        line_done_d  = 1'b1;
        frame_done_d = last_row;
        wr_sel_d     = wr_sel_q + 2'd1;
        ls_d         = (cur_ls == LS_FULL) ? LS_FULL : cur_ls + 3'd1;
        row_d        = last_row ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      ls_q         <= '0;
      wr_sel_q     <= '0;
      pix_q        <= '0;
      sel_q        <= '0;
      live_q       <= 1'b0;
      col_valid_q  <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef BORDER_REPLICATE_EN
      out_ls_q     <= '0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      ls_q         <= ls_d;
      wr_sel_q     <= wr_sel_d;
      pix_q        <= pix_d;
      sel_q        <= sel_d;
      live_q       <= live_d;
      col_valid_q  <= col_valid_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
`ifdef BORDER_REPLICATE_EN
      out_ls_q     <= out_ls_d;
`endif
    end
  end

  // All four RAMs are read at the current column; the one holding line r-4 is
  // overwritten with the incoming pixel in the same access.
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_ram
    line_ram #(
      .DEPTH (IMG_WIDTH),
      .AW    (CW)
    ) u_line_ram (
      .clk     (clk),
      .en      (accept),
      .we      (wr_sel_q == 2'(g)),
      .addr    (cur_col),
      .wr_data (pix_in),
      .rd_data (ram_rd[g])
    );
  end

  // RAM (sel+m) mod 4 holds line r-4+m. RAM read data and pix_q only change on
  // accepted pixels, so the assembled column holds between them.
  always_comb begin
    logic [1:0] idx;
`ifdef BORDER_REPLICATE_EN
    logic [2:0] n_above;
    pixel_t     line0;
`endif
    for (int m = 0; m < NUM_LINES; m++) begin
      idx          = sel_q + 2'(m);
      col_bytes[m] = ram_rd[idx];
    end
    col_bytes[NUM_LINES] = pix_q;
`ifdef BORDER_REPLICATE_EN
    // Line 0 sits in byte 4-lines_stored; bytes below it lie above the image.
    n_above = LS_FULL - out_ls_q;
    line0   = col_bytes[n_above];
    for (int k = 0; k < NUM_LINES; k++) begin
      if (3'(k) < n_above) begin
        col_bytes[k] = line0;
      end
    end
`endif
    for (int k = 0; k < WIN; k++) begin
      col_asm[k*PIX_W +: PIX_W] = col_bytes[k];
    end
  end

  assign col_out    = live_q ? col_asm : '0;
  assign col_valid  = col_valid_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buffer_5row.sv
// tb/tb_line_buffer_5row.sv - self-checking bench for line_buffer_5row (8x6 image)
module tb_line_buffer_5row;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix_in = 8'h00;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic [39:0] col_out;
  logic        col_valid;
  logic        line_done;
  logic        frame_done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [39:0] last_out = '0;
  bit          have_out = 1'b0;

  typedef struct {
    int          r;
    int          c;
    bit          pv;
    bit          sf;
    logic [7:0]  pix;
    bit          acc;
    bit          e_v;
    logic [39:0] e_col;
    bit          e_ld;
    bit          e_fd;
  } vec_t;

  vec_t tbl[$];

  line_buffer_5row #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .col_out    (col_out),
    .col_valid  (col_valid),
    .line_done  (line_done),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic bit model_valid(int r);
`ifdef BORDER_REPLICATE_EN
    return (r >= 0);
`else
    return (r >= 4);
`endif
  endfunction

  function automatic logic [39:0] model_col(int r, int c);
    logic [39:0] v;
    logic [31:0] lnb;
    logic [31:0] cb;
    int ln;
    cb = c;
    v  = '0;
    for (int k = 0; k < 5; k++) begin
      ln = r - 4 + k;
      if (ln < 0) ln = 0;
      lnb = ln;
      v[k*8 +: 8] = {lnb[3:0], cb[3:0]};
    end
    return v;
  endfunction

  function automatic vec_t mk(bit pv, bit sf, int r, int c, bit acc);
    vec_t v;
    logic [31:0] rb;
    logic [31:0] cb;
    rb      = r;
    cb      = c;
    v.r     = r;
    v.c     = c;
    v.pv    = pv;
    v.sf    = sf;
    v.pix   = {rb[3:0], cb[3:0]};
    v.acc   = acc;
    v.e_v   = acc && model_valid(r);
    v.e_col = model_col(r, c);
    v.e_ld  = acc && (c == W - 1);
    v.e_fd  = acc && (c == W - 1) && (r == H - 1);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    string nm;
    nm        = $sformatf("%s r%0d c%0d pv%0d", tag, v.r, v.c, v.pv);
    pix_valid = v.pv;
    sof       = v.sf;
    pix_in    = v.pix;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    chk({nm, " col_valid"}, {39'd0, col_valid}, {39'd0, v.e_v});
    chk({nm, " line_done"}, {39'd0, line_done}, {39'd0, v.e_ld});
    chk({nm, " frame_done"}, {39'd0, frame_done}, {39'd0, v.e_fd});
    if (v.e_v) begin
      chk({nm, " col_out"}, col_out, v.e_col);
      last_out = v.e_col;
      have_out = 1'b1;
    end else if (!v.acc && have_out) begin
      chk({nm, " col_out held"}, col_out, last_out);
    end else if (v.acc) begin
      have_out = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " col_out"}, col_out, 40'h0);
    chk({tag, " col_valid"}, {39'd0, col_valid}, 40'h0);
    chk({tag, " line_done"}, {39'd0, line_done}, 40'h0);
    chk({tag, " frame_done"}, {39'd0, frame_done}, 40'h0);
    last_out = '0;
    have_out = 1'b1;
  endtask

  task automatic run_frame(input string tag);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        apply(mk(1'b1, (r == 0 && c == 0), r, c, 1'b1), tag);
      end
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Tests 1/2: full frame, continuous valid, table driven
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        tbl.push_back(mk(1'b1, (r == 0 && c == 0), r, c, 1'b1));
      end
    end
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], "t1");
      if (i == 4 * W) chk("t1 literal r4c0", col_out, 40'h40_30_20_10_00);
      if (i == 5 * W - 1) chk("t2 literal r4c7", col_out, 40'h47_37_27_17_07);
`ifdef BORDER_REPLICATE_EN
      if (i == 3) chk("t6 literal r0c3", col_out, 40'h03_03_03_03_03);
      if (i == 2 * W + 1) chk("t6 literal r2c1", col_out, 40'h21_11_01_01_01);
`endif
    end
    // Frame complete: FSM idle, pixels without sof are dropped
    apply(mk(1'b1, 1'b0, 0, 0, 1'b0), "t2 idle drop");
    apply(mk(1'b1, 1'b0, 0, 1, 1'b0), "t2 idle drop");

    // Test 3: pix_valid toggling every cycle
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        apply(mk(1'b1, (r == 0 && c == 0), r, c, 1'b1), "t3");
        apply(mk(1'b0, 1'b0, r, c, 1'b0), "t3 gap");
      end
    end

    // Test 4: sof at row 2 col 3 restarts the frame
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < 2 || c < 3) apply(mk(1'b1, (r == 0 && c == 0), r, c, 1'b1), "t4 pre");
      end
    end
    run_frame("t4");

    // Test 5: reset at row 4 col 2
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < 4 || c < 2) apply(mk(1'b1, (r == 0 && c == 0), r, c, 1'b1), "t5 pre");
      end
    end
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 8'h42;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    pix_valid = 1'b0;
    check_zero("t5 after rst");
    for (int c = 0; c < 3; c++) begin
      apply(mk(1'b1, 1'b0, 4, c + 3, 1'b0), "t5 no sof");
    end
    run_frame("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
